// File: rtl/int_pkg.sv
// rtl/int_pkg.sv - shared state encodings, default addresses and word-match helper for int_gen
package int_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_HOLDOFF = 2'd2,
    ST_DONE    = 2'd3
  } int_state_t;

  localparam logic [31:0] DEFAULT_TARGET_PC = 32'h0000_3010;
  localparam logic [31:0] DEFAULT_ACK_ADDR  = 32'h0000_7f20;
  localparam logic [31:0] WORD_MASK         = 32'hffff_fffc;

  // True when addr falls anywhere inside the word at ref_addr.
  function automatic logic word_match(input logic [31:0] addr, input logic [31:0] ref_addr);
    return (addr & WORD_MASK) == ref_addr;
  endfunction

endpackage

// File: rtl/int_gen.sv
// rtl/int_gen.sv - one-shot-per-PC external interrupt generator with store ack and timeout abort
//
// Ports:
//   clk            sole clock, rising edge
//   reset          asynchronous active-high reset
//   arm            enables new triggers from IDLE
//   macroscopic_pc CPU macroscopic PC, compared at word granularity
//   m_int_addr     CPU store address
//   m_int_byteen   CPU store byte enables (any set bit = store)
//   interrupt      registered interrupt request, high only in ASSERT
//   fire_count     acknowledged interrupts since reset, saturates at 255
//   timeout_err    sticky flag: an interrupt went unacknowledged too long
//   state          current FSM state
module int_gen
  import int_pkg::*;
#(
  parameter logic [31:0] TARGET_PC = DEFAULT_TARGET_PC,
  parameter logic [31:0] ACK_ADDR  = DEFAULT_ACK_ADDR,
  parameter int unsigned MAX_FIRES = 1,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        arm,
  input  logic [31:0] macroscopic_pc,
  input  logic [31:0] m_int_addr,
  input  logic [3:0]  m_int_byteen,
  output logic        interrupt,
  output logic [7:0]  fire_count,
  output logic        timeout_err,
  output logic [1:0]  state
);

  localparam logic [7:0]  MAX_FC  = 8'(MAX_FIRES);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  logic       w_pc_hit;
  logic       w_ack_hit;

  int_state_t  r_state;
  logic        r_interrupt;
  logic [7:0]  r_fire_count;
  logic        r_timeout_err;
  logic [15:0] r_tcnt;

  assign w_pc_hit  = word_match(macroscopic_pc, TARGET_PC);
  assign w_ack_hit = (|m_int_byteen) && word_match(m_int_addr, ACK_ADDR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_interrupt   <= 1'b0;
      r_fire_count  <= 8'd0;
      r_timeout_err <= 1'b0;
      r_tcnt        <= 16'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (arm && w_pc_hit && (r_fire_count < MAX_FC)) begin
            r_state     <= ST_ASSERT;
            r_interrupt <= 1'b1;
            r_tcnt      <= 16'd0;
          end
        end
        ST_ASSERT: begin
          // Ack is tested first so an ack on the last allowed cycle still counts.
          if (w_ack_hit) begin
            r_state     <= ST_HOLDOFF;
            r_interrupt <= 1'b0;
            if (r_fire_count != 8'hff) begin
              r_fire_count <= r_fire_count + 8'd1;
            end
          end else if (r_tcnt == TO_LAST) begin
            r_state       <= ST_DONE;
            r_interrupt   <= 1'b0;
            r_timeout_err <= 1'b1;
          end else begin
            r_tcnt <= r_tcnt + 16'd1;
          end
        end
        ST_HOLDOFF: begin
          // Wait for the PC to leave the target so one occupancy fires once.
          if (!w_pc_hit) begin
            r_state <= (r_fire_count == MAX_FC) ? ST_DONE : ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_DONE;
          r_interrupt <= 1'b0;
        end
      endcase
    end
  end

  assign interrupt   = r_interrupt;
  assign fire_count  = r_fire_count;
  assign timeout_err = r_timeout_err;
  assign state       = r_state;

endmodule

// File: tb/tb_int_gen.sv
// tb/tb_int_gen.sv - scoreboard bench for int_gen, two instances (MAX_FIRES 1 and 2, TIMEOUT 8)
module tb_int_gen;
  import int_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        arm_a = 1'b0;
  logic        arm_b = 1'b0;
  logic [31:0] macroscopic_pc = 32'd0;
  logic [31:0] m_int_addr = 32'd0;
  logic [3:0]  m_int_byteen = 4'd0;

  logic        int_a, int_b;
  logic [7:0]  fc_a, fc_b;
  logic        err_a, err_b;
  logic [1:0]  st_a, st_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  int_gen #(.MAX_FIRES(1), .TIMEOUT(8)) u_dut_a (
    .clk(clk), .reset(reset), .arm(arm_a), .macroscopic_pc(macroscopic_pc),
    .m_int_addr(m_int_addr), .m_int_byteen(m_int_byteen),
    .interrupt(int_a), .fire_count(fc_a), .timeout_err(err_a), .state(st_a)
  );

  int_gen #(.MAX_FIRES(2), .TIMEOUT(8)) u_dut_b (
    .clk(clk), .reset(reset), .arm(arm_b), .macroscopic_pc(macroscopic_pc),
    .m_int_addr(m_int_addr), .m_int_byteen(m_int_byteen),
    .interrupt(int_b), .fire_count(fc_b), .timeout_err(err_b), .state(st_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour, one entry per instance.
  logic [1:0]  m_st  [2];
  logic        m_int [2];
  logic [7:0]  m_fc  [2];
  logic        m_err [2];
  logic [15:0] m_tc  [2];
  int          m_max [2] = '{1, 2};
  int          m_to  [2] = '{8, 8};

  typedef struct {
    int         inst;
    logic       intr;
    logic [7:0] fc;
    logic       err;
    logic [1:0] st;
  } exp_t;
  exp_t sb_q[$];

  int   hi_a = 0;
  int   rise_b = 0;
  logic prev_b = 1'b0;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 2'd0; m_int[k] = 1'b0; m_fc[k] = 8'd0; m_err[k] = 1'b0; m_tc[k] = 16'd0;
    end
  endtask

  task automatic model_step(input int k, input logic arm_k);
    logic pc_hit, ack;
    pc_hit = (macroscopic_pc & 32'hffff_fffc) == 32'h0000_3010;
    ack    = (m_int_byteen != 4'd0) && ((m_int_addr & 32'hffff_fffc) == 32'h0000_7f20);
    if (m_st[k] == 2'd0) begin
      if (arm_k && pc_hit && (int'(m_fc[k]) < m_max[k])) begin
        m_st[k] = 2'd1; m_int[k] = 1'b1; m_tc[k] = 16'd0;
      end
    end else if (m_st[k] == 2'd1) begin
      if (ack) begin
        m_st[k] = 2'd2; m_int[k] = 1'b0;
        if (m_fc[k] != 8'hff) m_fc[k] = m_fc[k] + 8'd1;
      end else if (int'(m_tc[k]) == m_to[k] - 1) begin
        m_st[k] = 2'd3; m_int[k] = 1'b0; m_err[k] = 1'b1;
      end else begin
        m_tc[k] = m_tc[k] + 16'd1;
      end
    end else if (m_st[k] == 2'd2) begin
      if (!pc_hit) m_st[k] = (int'(m_fc[k]) == m_max[k]) ? 2'd3 : 2'd0;
    end
  endtask

  // Called at a falling edge: drive, predict, push; compare at the next falling edge.
  task automatic cycle(input logic [31:0] pc_v, input logic [31:0] addr_v, input logic [3:0] be_v,
                       input logic a_arm, input logic b_arm);
    exp_t e;
    macroscopic_pc = pc_v; m_int_addr = addr_v; m_int_byteen = be_v;
    arm_a = a_arm; arm_b = b_arm;
    model_step(0, a_arm);
    model_step(1, b_arm);
    for (int k = 0; k < 2; k++) begin
      e.inst = k; e.intr = m_int[k]; e.fc = m_fc[k]; e.err = m_err[k]; e.st = m_st[k];
      sb_q.push_back(e);
    end
    @(negedge clk);
    if (int_a) hi_a++;
    if (int_b && !prev_b) rise_b++;
    prev_b = int_b;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.inst == 0) begin
        check("a_interrupt", {31'd0, int_a}, {31'd0, e.intr});
        check("a_fire_count", {24'd0, fc_a}, {24'd0, e.fc});
        check("a_timeout_err", {31'd0, err_a}, {31'd0, e.err});
        check("a_state", {30'd0, st_a}, {30'd0, e.st});
      end else begin
        check("b_interrupt", {31'd0, int_b}, {31'd0, e.intr});
        check("b_fire_count", {24'd0, fc_b}, {24'd0, e.fc});
        check("b_timeout_err", {31'd0, err_b}, {31'd0, e.err});
        check("b_state", {30'd0, st_b}, {30'd0, e.st});
      end
    end
  endtask

  task automatic step_a(input logic [31:0] pc_v, input logic [31:0] addr_v, input logic [3:0] be_v);
    cycle(pc_v, addr_v, be_v, 1'b1, 1'b0);
  endtask

  task automatic step_b(input logic [31:0] pc_v, input logic [31:0] addr_v, input logic [3:0] be_v);
    cycle(pc_v, addr_v, be_v, 1'b0, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_int"}, {30'd0, int_a, int_b}, 32'd0);
    check({tag, "_fc"}, {16'd0, fc_a, fc_b}, 32'd0);
    check({tag, "_err"}, {30'd0, err_a, err_b}, 32'd0);
    check({tag, "_state"}, {28'd0, st_a, st_b}, 32'd0);
  endtask

  // Entered and left at a falling edge.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    arm_a = 1'b0; arm_b = 1'b0;
    macroscopic_pc = 32'd0; m_int_addr = 32'd0; m_int_byteen = 4'd0;
    model_reset();
    prev_b = 1'b0;
    @(negedge clk);
    check_all_zero(tag);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    do_reset("rst0");

    // Walk up to the target PC.
    for (int i = 0; i < 5; i++) step_a(32'h3000 + 32'(4 * i), 32'd0, 4'd0);
    check("t1_int_high", {31'd0, int_a}, 32'd1);
    check("t1_state", {30'd0, st_a}, 32'(ST_ASSERT));
    cycle(32'h3010, 32'd0, 4'd0, 1'b0, 1'b0);
    check("t1_arm_low_holds", {31'd0, int_a}, 32'd1);

    // Sub-word store into the ack word.
    step_a(32'h3010, 32'h7f22, 4'b0001);
    check("t2_int_low", {31'd0, int_a}, 32'd0);
    check("t2_fc", {24'd0, fc_a}, 32'd1);
    check("t2_holdoff", {30'd0, st_a}, 32'(ST_HOLDOFF));
    step_a(32'h3010, 32'd0, 4'd0);
    step_a(32'h3014, 32'd0, 4'd0);
    check("t2_done", {30'd0, st_a}, 32'(ST_DONE));
    step_a(32'h3010, 32'h7f20, 4'b1111);
    step_a(32'h3010, 32'd0, 4'd0);
    check("t2_done_stays", {31'd0, int_a}, 32'd0);

    // Unacknowledged interrupt times out after 8 cycles.
    do_reset("rst4");
    step_a(32'h300c, 32'd0, 4'd0);
    hi_a = 0;
    step_a(32'h3010, 32'd0, 4'd0);
    for (int i = 0; i < 12; i++) step_a(32'h3020, 32'd0, 4'd0);
    check("t4_high_cycles", 32'(hi_a), 32'd8);
    check("t4_err", {31'd0, err_a}, 32'd1);
    check("t4_state", {30'd0, st_a}, 32'(ST_DONE));

    // Ack while idle is ignored; ack on the last timeout cycle wins.
    do_reset("rst5");
    step_a(32'h3000, 32'h7f20, 4'b1111);
    check("t5_idle_ack", {24'd0, fc_a}, 32'd0);
    step_a(32'h3010, 32'd0, 4'd0);
    for (int i = 0; i < 7; i++) step_a(32'h3010, 32'd0, 4'd0);
    check("t5_still_high", {31'd0, int_a}, 32'd1);
    step_a(32'h3010, 32'h7f20, 4'b0100);
    check("t5_fc", {24'd0, fc_a}, 32'd1);
    check("t5_err", {31'd0, err_a}, 32'd0);
    check("t5_state", {30'd0, st_a}, 32'(ST_HOLDOFF));

    // Two acknowledged passes on the MAX_FIRES=2 instance, then no more.
    do_reset("rst3");
    rise_b = 0;
    for (int p = 0; p < 2; p++) begin
      step_b(32'h300c, 32'd0, 4'd0);
      step_b(32'h3010, 32'd0, 4'd0);
      step_b(32'h3010, 32'h7f20, 4'b1000);
      step_b(32'h3014, 32'd0, 4'd0);
    end
    check("t3_fc", {24'd0, fc_b}, 32'd2);
    check("t3_state", {30'd0, st_b}, 32'(ST_DONE));
    step_b(32'h300c, 32'd0, 4'd0);
    step_b(32'h3010, 32'd0, 4'd0);
    step_b(32'h3010, 32'd0, 4'd0);
    check("t3_pulses", 32'(rise_b), 32'd2);
    check("t3_third_pass", {31'd0, int_b}, 32'd0);

    // Reset between edges must drop the interrupt at once.
    do_reset("rst6a");
    step_a(32'h3010, 32'd0, 4'd0);
    check("t6_pre", {31'd0, int_a}, 32'd1);
    reset = 1'b1;
    #1;
    check("t6_int_async", {31'd0, int_a}, 32'd0);
    check_all_zero("t6_async");
    do_reset("rst6b");
    step_a(32'h3010, 32'd0, 4'd0);
    check("t6_retrigger", {31'd0, int_a}, 32'd1);
    step_a(32'h3010, 32'h7f20, 4'b0010);
    check("t6_retrigger_fc", {24'd0, fc_a}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/int_gen.md
INT_GEN -- requirements
Module: int_gen

Interface
REQ-001 SHALL have parameter TARGET_PC, default 32'h0000_3010, word-aligned PC that triggers an interrupt.
REQ-002 SHALL have parameter ACK_ADDR, default 32'h0000_7f20, word address whose store acknowledges the interrupt.
REQ-003 SHALL have parameter MAX_FIRES, default 1, maximum interrupts per reset (1..255).
REQ-004 SHALL have parameter TIMEOUT, default 1024, cycles allowed in ASSERT before abort (1..65535).
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port arm  input  1  enables new triggers.
REQ-008 SHALL have port macroscopic_pc  input  32  CPU macroscopic PC.
REQ-009 SHALL have port m_int_addr  input  32  CPU store address.
REQ-010 SHALL have port m_int_byteen  input  4  CPU store byte enables.
REQ-011 SHALL have port interrupt  output  1  external interrupt request to CPU.
REQ-012 SHALL have port fire_count  output  8  number of acknowledged interrupts.
REQ-013 SHALL have port timeout_err  output  1  sticky abort flag.
REQ-014 SHALL have port state  output  2  current FSM state.

Function
REQ-015 SHALL compare the PC masked to a word, i.e. macroscopic_pc & 32'hffff_fffc, against TARGET_PC (pc_hit).
REQ-016 SHALL detect an ack when |m_int_byteen and (m_int_addr & 32'hffff_fffc) == ACK_ADDR (ack_hit).
REQ-017 SHALL implement states IDLE=0, ASSERT=1, HOLDOFF=2, DONE=3.
REQ-018 IDLE: arm && pc_hit && fire_count < MAX_FIRES SHALL move to ASSERT, with interrupt registered high on that same edge (1-cycle latency from pc_hit).
REQ-019 ASSERT: interrupt SHALL stay high; deasserting arm SHALL NOT drop it.
REQ-020 ASSERT: ack_hit SHALL clear interrupt, increment fire_count (saturating at 255) and move to HOLDOFF on the next edge.
REQ-021 ASSERT: the timeout counter (16 bit) SHALL increment each cycle; the counter reaching TIMEOUT-1 without ack_hit SHALL clear interrupt, set timeout_err and move to DONE.
REQ-022 If ack_hit and timeout occur in the same cycle, ack SHALL win (normal HOLDOFF path, no error).
REQ-023 The timeout counter SHALL be cleared on every entry to ASSERT.
REQ-024 HOLDOFF: it SHALL remain while pc_hit, preventing retrigger on the same PC occupancy; once !pc_hit, it SHALL go to DONE if fire_count == MAX_FIRES, else to IDLE.
REQ-025 DONE: absorbing state; interrupt SHALL stay 0 until reset.
REQ-026 ack_hit outside ASSERT SHALL be ignored (no count change).
REQ-027 All outputs SHALL be registered; interrupt SHALL be high only in ASSERT.

Reset
REQ-028 Reset SHALL asynchronously force state=IDLE, interrupt=0, fire_count=0, timeout_err=0 and timeout counter=0.
REQ-029 Reset during ASSERT SHALL drop interrupt immediately, without waiting for a clock edge.
REQ-030 After reset release, the first trigger SHALL require a rising clock edge with pc_hit.

Structure
REQ-031 State encodings and default TARGET_PC/ACK_ADDR SHALL live in shared package int_pkg, reused by the bridge and testbenches.
REQ-032 The block SHALL be a single module, with no sub-modules; the timeout counter is inline.

Verification
REQ-033 Test 1: arm=1, PC steps 0x3000..0x3010 -> interrupt high on the edge after PC=0x3010, state=1.
REQ-034 Test 2: from ASSERT, store byteen=4'b0001 at 0x7f22 -> interrupt low next edge, fire_count=1, state=2, then 3 once PC leaves 0x3010.
REQ-035 Test 3: MAX_FIRES=2, PC loops through 0x3010 twice with acks -> two pulses, fire_count=2, third pass gives no interrupt.
REQ-036 Test 4: TIMEOUT=8, no ack -> interrupt high exactly 8 cycles, timeout_err=1, state=3.
REQ-037 Test 5: ack on the final timeout cycle -> fire_count=1, timeout_err=0; also store to 0x7f20 while IDLE -> fire_count unchanged.
REQ-038 Test 6: reset pulse mid-ASSERT -> interrupt 0 before the next edge; all outputs 0; retrigger works after release.
